// File: rtl/ahb_slave_pkg.sv
// Shared definitions for the AHB slave RAM.
//   hsize_t   : AHB transfer-size encodings (byte .. doubleword)
//   state_t   : data-phase FSM states (IDLE, WAIT, DATA)
//   lanes_for_size : byte count of a transfer, clamped to the bus width
package ahb_slave_pkg;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'b000,
    HSIZE_HALF  = 3'b001,
    HSIZE_WORD  = 3'b010,
    HSIZE_DWORD = 3'b011
  } hsize_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DATA = 2'd2
  } state_t;

  // Sizes wider than the bus collapse to a full-width transfer.
  function automatic int unsigned lanes_for_size(input logic [2:0] size,
                                                 input int unsigned max_log2);
    int unsigned s;
    s = 32'(size);
    if (s > max_log2) s = max_log2;
    return 32'd1 << s;
  endfunction

endpackage

// File: rtl/ahb_slave_ram_array.sv
// Storage array for ahb_slave_ram.
//   clk, rst_n : clock, asynchronous active-low reset (clears every word)
//   we, waddr, wdata, wbe : synchronous write port with per-byte enables
//   raddr, rdata          : combinational read port
module ahb_slave_ram_array #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [DWIDTH-1:0]          wdata,
  input  logic [DWIDTH/8-1:0]        wbe,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [DWIDTH-1:0]          rdata
);

  localparam int unsigned NB = DWIDTH / 8;

  logic [DWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (wbe[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_slave_ram.sv
// AHB-style slave RAM with configurable wait states.
//   hclk, hresetN : bus clock, asynchronous active-low reset
//   hsel, haddr, hsize, hwrite : address phase, accepted when hsel & hready
//   hwdata        : write data, sampled in the DATA cycle
//   hrdata        : registered read data, valid in the DATA cycle, held otherwise
//   hready        : low only while the FSM is in WAIT
// Parameters: DWIDTH (32/64), DEPTH (words, power of 2), WAIT_STATES (0..7).
// Macro AHB_SLAVE_RAM_BYTE_LANES_EN enables sub-word writes; without it every
// write updates the full word.
module ahb_slave_ram
  import ahb_slave_pkg::*;
#(
  parameter int unsigned DWIDTH      = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              hclk,
  input  logic              hresetN,
  input  logic              hsel,
  input  logic [31:0]       haddr,
  input  logic [DWIDTH-1:0] hwdata,
  input  logic [2:0]        hsize,
  input  logic              hwrite,
  output logic [DWIDTH-1:0] hrdata,
  output logic              hready
);

  localparam int unsigned NB    = DWIDTH / 8;
  localparam int unsigned OFFW  = $clog2(NB);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned IDXHI = OFFW + AW;
  localparam logic [2:0]  WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  state_t            state, state_d;
  logic [2:0]        cnt, cnt_d;
  logic              accept;

  logic [AW-1:0]     idx_q;
  logic [OFFW-1:0]   off_q;
  logic [2:0]        size_q;
  logic              write_q;

  logic              wr_en;
  logic [NB-1:0]     wbe;
  logic [AW-1:0]     rd_idx;
  logic              rd_is_read;
  logic              rd_go;
  logic [DWIDTH-1:0] mem_rdata;
  logic [DWIDTH-1:0] rd_word;
  logic [DWIDTH-1:0] hrdata_q;

  logic              unused_ok;
  assign unused_ok = ^{haddr[31:IDXHI], off_q, size_q};

`ifdef AHB_SLAVE_RAM_BYTE_LANES_EN
  // Little-endian lane select: the size-aligned group containing the offset.
  function automatic logic [NB-1:0] lane_mask(input logic [2:0] size,
                                              input logic [OFFW-1:0] off);
    int unsigned n;
    int unsigned base;
    logic [NB-1:0] m;
    n    = lanes_for_size(size, OFFW);
    base = 32'(off) & ~(n - 32'd1);
    m    = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      m[i] = (i >= base) && (i < base + n);
    end
    return m;
  endfunction

  assign wbe = lane_mask(size_q, off_q);
`else
  assign wbe = '1;
`endif

  assign accept = hsel && hready;

  // FSM state and wait counter
  always_ff @(posedge hclk or negedge hresetN) begin
    if (!hresetN) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    hready  = 1'b1;
    case (state)
      IDLE, DATA: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_d = DATA;
          end else begin
            state_d = WAIT;
            cnt_d   = WS_LOAD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        hready = 1'b0;
        if (cnt == '0) state_d = DATA;
        else           cnt_d   = cnt - 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address-phase capture
  always_ff @(posedge hclk or negedge hresetN) begin
    if (!hresetN) begin
      idx_q   <= '0;
      off_q   <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
    end else if (accept) begin
      idx_q   <= haddr[OFFW +: AW];
      off_q   <= haddr[OFFW-1:0];
      size_q  <= hsize;
      write_q <= hwrite;
    end
  end

  assign wr_en = (state == DATA) && write_q;

  // hrdata is loaded on the edge that enters DATA. From WAIT the transfer is
  // already registered; with zero wait states it is the one being accepted
  // now, so the live address bus selects the word.
  always_comb begin
    rd_idx     = (state == WAIT) ? idx_q : haddr[OFFW +: AW];
    rd_is_read = (state == WAIT) ? !write_q : !hwrite;
    rd_go      = (state_d == DATA) && rd_is_read;
  end

  // A write committing on this same edge is not yet in the array; merge its
  // enabled lanes over the stored word.
  always_comb begin
    rd_word = mem_rdata;
    if (wr_en && (rd_idx == idx_q)) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (wbe[b]) rd_word[b*8 +: 8] = hwdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetN) begin
    if (!hresetN)   hrdata_q <= '0;
    else if (rd_go) hrdata_q <= rd_word;
  end

  assign hrdata = hrdata_q;

  ahb_slave_ram_array #(
    .DWIDTH(DWIDTH),
    .DEPTH (DEPTH)
  ) u_array (
    .clk  (hclk),
    .rst_n(hresetN),
    .we   (wr_en),
    .waddr(idx_q),
    .wdata(hwdata),
    .wbe  (wbe),
    .raddr(rd_idx),
    .rdata(mem_rdata)
  );

endmodule

// File: doc/ahb_slave_ram.md
AHB_SLAVE_RAM -- requirements
Module: ahb_slave_ram

Interface
REQ-001 Parameter DWIDTH, default 32: data bus width; legal values 32 or 64.
REQ-002 Parameter DEPTH, default 16: number of DWIDTH-bit storage words; power of 2.
REQ-003 Parameter WAIT_STATES, default 1: hready-low cycles inserted per transfer; legal range 0..7.
REQ-004 hclk  input  1: bus clock; all state updates on the rising edge.
REQ-005 hresetN  input  1: reset, asynchronous, active-low.
REQ-006 hsel  input  1: slave select, qualifies the address phase.
REQ-007 haddr  input  32: transfer byte address.
REQ-008 hwdata  input  DWIDTH: write data, valid in the data phase.
REQ-009 hsize  input  3: transfer size; 000 byte, 001 halfword, 010 word, 011 doubleword.
REQ-010 hwrite  input  1: 1 write, 0 read.
REQ-011 hrdata  output  DWIDTH: read data to master.
REQ-012 hready  output  1: 1 = current data phase completes this cycle / slave can accept a new address.

Function
REQ-013 The block SHALL accept an address phase in any cycle where hsel=1 and hready=1, registering haddr, hsize and hwrite.
REQ-014 The word index SHALL be haddr[log2(DWIDTH/8) +: log2(DEPTH)]; upper address bits are ignored, so addresses wrap modulo DEPTH words.
REQ-015 The FSM SHALL have states IDLE, WAIT and DATA; IDLE and DATA drive hready=1, WAIT drives hready=0.
REQ-016 Accepted address with WAIT_STATES=0 -> DATA next cycle; with WAIT_STATES>0 -> WAIT, load the wait counter with WAIT_STATES-1.
REQ-017 WAIT SHALL decrement the counter each cycle and go to DATA the cycle after it reaches 0, giving exactly WAIT_STATES hready-low cycles.
REQ-018 DATA with a new accepted address SHALL proceed as in REQ-016 (pipelined back-to-back); DATA without one SHALL return to IDLE.
REQ-019 A write SHALL sample hwdata in the DATA cycle and commit it at that cycle's closing edge.
REQ-020 Read data SHALL be registered and valid on hrdata in the DATA cycle; hrdata SHALL hold its last value at all other times.
REQ-021 A read whose address phase coincides with the DATA cycle of a write to the same word SHALL return the new write data (forwarding, including merged lanes per REQ-027).
REQ-022 hsel=0 in an hready=1 cycle SHALL NOT start a transfer; hsel and the address inputs are ignored while hready=0.
REQ-023 hsize values above log2(DWIDTH/8) SHALL be treated as a full-width transfer.

Reset
REQ-024 While hresetN=0: state IDLE, hready=1, hrdata=0, wait counter 0, all storage words 0.
REQ-025 Reset asserted mid-transfer SHALL abandon the transfer with no storage update; the first accepted address after deassertion starts cleanly.

Configuration
REQ-026 Macro AHB_SLAVE_RAM_BYTE_LANES_EN selects sub-word write support.
REQ-027 Defined: writes update only the byte lanes selected by hsize and the low haddr bits (little-endian); other lanes keep their value.
REQ-028 Undefined: every write updates the full word regardless of hsize and the low address bits; reads are always full width in both cases.

Structure
REQ-029 Package ahb_slave_pkg SHALL hold the hsize encodings (HSIZE_BYTE, HSIZE_HALF, HSIZE_WORD, HSIZE_DWORD) and the state enum (IDLE, WAIT, DATA).
REQ-030 Storage SHALL be a sub-module ahb_slave_ram_array: one synchronous write port with byte enables and one combinational read port; FSM, counter and forwarding stay in the top module.

Verification
REQ-031 Reset, then hsel=0 for 10 cycles -> hready=1, hrdata=0 throughout, no storage change.
REQ-032 WAIT_STATES=2, write 0xDEADBEEF to 0x08, then read 0x08 -> each transfer shows 2 hready-low cycles; hrdata=0xDEADBEEF in the read DATA cycle.
REQ-033 WAIT_STATES=0, back-to-back write 0x12345678 to 0x04 then read 0x04 -> hready stays 1; read returns 0x12345678 (forwarding).
REQ-034 DEPTH=16, write 0xA5A5A5A5 to 0x40, read 0x00 -> returns 0xA5A5A5A5 (wrap).
REQ-035 BYTE_LANES_EN defined: word 0x00 = 0x11223344, byte write 0xFF at 0x01 -> read 0x1122FF44; undefined -> full-word write of the hwdata value.
REQ-036 Assert hresetN low during WAIT of a write to 0x0C -> hready=1 immediately; read 0x0C after release returns 0.
